// File: rtl/and2_mon_pkg.sv
// Shared types and elaboration-time helpers for the AND-gate result monitor.
package and2_mon_pkg;

   typedef enum logic [1:0] {
      LOW   = 2'd0,
      HIGH  = 2'd1,
      STUCK = 2'd2
   } mon_state_t;

   // All-ones value of a w-bit counter.
   function automatic int unsigned sat_max(input int unsigned w);
      return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
   endfunction

   function automatic bit params_ok(input int unsigned sync_stages,
                                    input int unsigned run_w,
                                    input int unsigned stuck_limit);
      return (sync_stages >= 2) && (sync_stages <= 4) &&
             (stuck_limit >= 1) && (stuck_limit <= sat_max(run_w));
   endfunction

endpackage

// File: rtl/and2_sync_ff.sv
// N-stage flop synchroniser with synchronous active-high reset.
// Latency STAGES cycles from i_d to o_q; no flow control.
module and2_sync_ff #(
   parameter int STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic i_d,
   output logic o_q
);

   logic [STAGES-1:0] r_chain;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_chain <= '0;
      end else begin
         r_chain <= {r_chain[STAGES-2:0], i_d};
      end
   end

   assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/and2_result_monitor.sv
// Monitors a registered AND result: rising-edge count, longest high run, sticky stuck-at-1 alarm.
// Statistics update one cycle after the synchronised input; no backpressure, all outputs registered.
module and2_result_monitor
   import and2_mon_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 16,
   parameter int RUN_W       = 8,
   parameter int STUCK_LIMIT = 100
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             c_in,
   input  logic             clear,
   output logic             c_sync,
   output logic [CNT_W-1:0] rise_count,
   output logic [RUN_W-1:0] high_run_max,
   output logic             alarm,
   output logic [1:0]       state
);

   generate
      if (!params_ok(SYNC_STAGES, RUN_W, STUCK_LIMIT)) begin : g_bad_params
         $error("and2_result_monitor: illegal SYNC_STAGES/RUN_W/STUCK_LIMIT combination");
      end
   endgenerate

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(sat_max(CNT_W));
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(sat_max(RUN_W));
   localparam logic [RUN_W-1:0] LIMIT   = RUN_W'(STUCK_LIMIT);

   logic             w_c_sync;
   logic             w_rise;
   logic             w_enter_stuck;
   logic [RUN_W-1:0] w_run_nxt;
   mon_state_t       w_state_nxt;

   logic             r_prev;
   logic [RUN_W-1:0] r_run_cnt;
   logic [CNT_W-1:0] r_rise_count;
   logic [RUN_W-1:0] r_high_run_max;
   logic             r_alarm;
   mon_state_t       r_state;

   and2_sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (c_in),
      .o_q   (w_c_sync)
   );

   assign w_rise    = w_c_sync & ~r_prev;
   assign w_run_nxt = !w_c_sync           ? '0      :
                      (r_run_cnt == RUN_MAX) ? RUN_MAX : r_run_cnt + 1'b1;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         LOW: begin
            if (w_c_sync) w_state_nxt = (w_run_nxt >= LIMIT) ? STUCK : HIGH;
         end
         HIGH: begin
            if (!w_c_sync)               w_state_nxt = LOW;
            else if (w_run_nxt >= LIMIT) w_state_nxt = STUCK;
         end
         STUCK: begin
            if (!w_c_sync) w_state_nxt = LOW;
         end
         default: w_state_nxt = LOW;
      endcase
   end

   // Alarm fires only on the transition into STUCK, so a clear while stuck stays cleared.
   assign w_enter_stuck = (w_state_nxt == STUCK) && (r_state != STUCK);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= LOW;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev         <= 1'b0;
         r_run_cnt      <= '0;
         r_rise_count   <= '0;
         r_high_run_max <= '0;
         r_alarm        <= 1'b0;
      end else begin
         r_prev    <= w_c_sync;
         r_run_cnt <= w_run_nxt;
         if (clear) begin
            r_rise_count   <= '0;
            r_high_run_max <= '0;
            r_alarm        <= 1'b0;
         end else begin
            if (w_rise && (r_rise_count != CNT_MAX)) r_rise_count <= r_rise_count + 1'b1;
            if (w_run_nxt > r_high_run_max)          r_high_run_max <= w_run_nxt;
            if (w_enter_stuck)                       r_alarm <= 1'b1;
         end
      end
   end

   assign c_sync       = w_c_sync;
   assign rise_count   = r_rise_count;
   assign high_run_max = r_high_run_max;
   assign alarm        = r_alarm;
   assign state        = r_state;

endmodule

// File: tb/tb_and2_result_monitor.sv
// Directed bench: three monitor instances (default, STUCK_LIMIT=5, narrow counters) share clk/reset/clear.
module tb_and2_result_monitor;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        clear = 1'b0;
   logic        c_in_a = 1'b0;
   logic        c_in_b = 1'b0;
   logic        c_in_c = 1'b0;

   logic        c_sync_a, c_sync_b, c_sync_c;
   logic [15:0] rise_a, rise_b;
   logic [2:0]  rise_c;
   logic [7:0]  max_a, max_b;
   logic [2:0]  max_c;
   logic        alarm_a, alarm_b, alarm_c;
   logic [1:0]  state_a, state_b, state_c;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   and2_result_monitor dut_a (
      .clk(clk), .reset(reset), .c_in(c_in_a), .clear(clear),
      .c_sync(c_sync_a), .rise_count(rise_a), .high_run_max(max_a),
      .alarm(alarm_a), .state(state_a)
   );

   and2_result_monitor #(.STUCK_LIMIT(5)) dut_b (
      .clk(clk), .reset(reset), .c_in(c_in_b), .clear(clear),
      .c_sync(c_sync_b), .rise_count(rise_b), .high_run_max(max_b),
      .alarm(alarm_b), .state(state_b)
   );

   and2_result_monitor #(.CNT_W(3), .RUN_W(3), .STUCK_LIMIT(7)) dut_c (
      .clk(clk), .reset(reset), .c_in(c_in_c), .clear(clear),
      .c_sync(c_sync_c), .rise_count(rise_c), .high_run_max(max_c),
      .alarm(alarm_c), .state(state_c)
   );

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      reset  = 1'b1;
      c_in_a = 1'b0;
      c_in_b = 1'b0;
      c_in_c = 1'b0;
      tick(3);
      reset = 1'b0;
   endtask

   initial begin
      tick(1);

      // 1. Reset held with c_in high
      reset  = 1'b1;
      c_in_a = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("rst_c_sync", 32'(c_sync_a), 32'd0);
         check("rst_rise",   32'(rise_a),   32'd0);
         check("rst_max",    32'(max_a),    32'd0);
         check("rst_alarm",  32'(alarm_a),  32'd0);
         check("rst_state",  32'(state_a),  32'd0);
      end
      reset = 1'b0;
      tick(1);
      check("rel_c_sync_1", 32'(c_sync_a), 32'd0);
      tick(1);
      check("rel_c_sync_2", 32'(c_sync_a), 32'd1);
      check("rel_rise_2",   32'(rise_a),   32'd0);
      tick(1);
      check("rel_rise_3",   32'(rise_a),   32'd1);
      check("rel_state_3",  32'(state_a),  32'd1);

      // 2. Single 3-cycle pulse
      do_reset();
      c_in_a = 1'b1;
      tick(1);
      check("pulse_c_sync_e1", 32'(c_sync_a), 32'd0);
      tick(1);
      check("pulse_c_sync_e2", 32'(c_sync_a), 32'd1);
      tick(1);
      c_in_a = 1'b0;
      check("pulse_c_sync_e3", 32'(c_sync_a), 32'd1);
      tick(1);
      check("pulse_c_sync_e4", 32'(c_sync_a), 32'd1);
      check("pulse_state_e4",  32'(state_a),  32'd1);
      tick(1);
      check("pulse_c_sync_e5", 32'(c_sync_a), 32'd0);
      tick(2);
      check("pulse_rise",  32'(rise_a),  32'd1);
      check("pulse_max",   32'(max_a),   32'd3);
      check("pulse_alarm", 32'(alarm_a), 32'd0);
      check("pulse_state", 32'(state_a), 32'd0);

      // 3. Stuck with STUCK_LIMIT=5, 10 high cycles
      do_reset();
      c_in_b = 1'b1;
      tick(2);
      check("stuck_c_sync", 32'(c_sync_b), 32'd1);
      tick(4);
      check("stuck_alarm_e6", 32'(alarm_b), 32'd0);
      check("stuck_state_e6", 32'(state_b), 32'd1);
      tick(1);
      check("stuck_alarm_e7", 32'(alarm_b), 32'd1);
      check("stuck_state_e7", 32'(state_b), 32'd2);
      tick(3);
      c_in_b = 1'b0;
      tick(3);
      check("stuck_state_end", 32'(state_b), 32'd0);
      check("stuck_alarm_end", 32'(alarm_b), 32'd1);
      check("stuck_max_end",   32'(max_b),   32'd10);
      check("stuck_rise_end",  32'(rise_b),  32'd1);

      // 4. Saturation with 3-bit counters
      do_reset();
      for (int i = 0; i < 10; i++) begin
         c_in_c = 1'b1;
         tick(1);
         c_in_c = 1'b0;
         tick(1);
      end
      tick(3);
      check("sat_c_sync_idle", 32'(c_sync_c), 32'd0);
      check("sat_rise_pulses", 32'(rise_c),   32'd7);
      check("sat_max_pulses",  32'(max_c),    32'd1);
      c_in_c = 1'b1;
      tick(12);
      c_in_c = 1'b0;
      tick(4);
      check("sat_rise_final",  32'(rise_c),  32'd7);
      check("sat_max_final",   32'(max_c),   32'd7);
      check("sat_alarm_final", 32'(alarm_c), 32'd1);
      check("sat_state_final", 32'(state_c), 32'd0);

      // 5. Clear coinciding with a rise
      do_reset();
      c_in_a = 1'b1;
      tick(2);
      clear = 1'b1;
      tick(1);
      clear  = 1'b0;
      c_in_a = 1'b0;
      check("clr_rise_drop", 32'(rise_a), 32'd0);
      check("clr_max_drop",  32'(max_a),  32'd0);
      tick(2);
      check("clr_max_resume",  32'(max_a),  32'd3);
      check("clr_rise_resume", 32'(rise_a), 32'd0);
      tick(2);
      c_in_a = 1'b1;
      tick(1);
      c_in_a = 1'b0;
      tick(4);
      check("clr_next_rise", 32'(rise_a), 32'd1);

      // 6. Clear while STUCK, then re-enter STUCK
      do_reset();
      c_in_b = 1'b1;
      tick(7);
      check("cs_alarm_set", 32'(alarm_b), 32'd1);
      check("cs_state_set", 32'(state_b), 32'd2);
      clear = 1'b1;
      tick(1);
      clear = 1'b0;
      check("cs_alarm_clr", 32'(alarm_b), 32'd0);
      tick(3);
      check("cs_alarm_hold", 32'(alarm_b), 32'd0);
      check("cs_state_hold", 32'(state_b), 32'd2);
      c_in_b = 1'b0;
      tick(3);
      check("cs_state_low", 32'(state_b), 32'd0);
      check("cs_alarm_low", 32'(alarm_b), 32'd0);
      c_in_b = 1'b1;
      tick(6);
      check("cs_alarm_e6", 32'(alarm_b), 32'd0);
      tick(1);
      check("cs_alarm_e7", 32'(alarm_b), 32'd1);
      check("cs_state_e7", 32'(state_b), 32'd2);
      c_in_b = 1'b0;
      tick(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
